// File: rtl/nios_system_mem_test_master.sv
// Avalon-MM memory self-test master: writes seed+i over a word range, reads it back and counts mismatches.
// Define NIOS_SYSTEM_MEM_TEST_INVERT_PASS_EN to add a second pass with inverted data.
module nios_system_mem_test_master #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_data,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_READ,
`ifdef NIOS_SYSTEM_MEM_TEST_INVERT_PASS_EN
    S_INV_WRITE,
    S_INV_READ,
`endif
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W:0]   len_reg;
  logic [DATA_W-1:0] seed_reg;
  logic              clken_reg;

  logic              error_reg;
  logic [15:0]       err_count_reg;
  logic [ADDR_W-1:0] err_addr_reg;
  logic [DATA_W-1:0] err_data_reg;

  // Compare pipeline: request stage, then readdata capture stage.
  logic              rd_pend_reg;
  logic [DATA_W-1:0] exp1_reg;
  logic [ADDR_W-1:0] addr1_reg;
  logic              cmp_valid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] exp2_reg;
  logic [ADDR_W-1:0] addr2_reg;

  logic              cs, wr, pat_inv;
  logic              last_idx, rd_end, range_bad, mismatch;
  logic [DATA_W-1:0] pattern, exp_cur;

  assign last_idx  = (idx_reg == (len_reg - IDX_ONE));
  assign rd_end    = (idx_reg == len_reg);
  assign range_bad = (({1'b0, base_reg} + len_reg) > DEPTH_LIM);
  assign pattern   = seed_reg + DATA_W'(idx_reg);
  assign exp_cur   = pat_inv ? ~pattern : pattern;
  assign mismatch  = cmp_valid_reg && (rdata_reg != exp2_reg);

  // The final read phase holds one extra access-free cycle (idx == len) so the
  // last readdata is captured before DRAIN compares it.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cs         = 1'b0;
    wr         = 1'b0;
    pat_inv    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CHECK;
          idx_next   = '0;
        end
      end
      S_CHECK: begin
        if ((len_reg == '0) || range_bad) state_next = S_DONE;
        else                              state_next = S_WRITE;
      end
      S_WRITE: begin
        cs = 1'b1;
        wr = 1'b1;
        if (last_idx) begin
          idx_next   = '0;
          state_next = S_READ;
        end else begin
          idx_next = idx_reg + IDX_ONE;
        end
      end
`ifdef NIOS_SYSTEM_MEM_TEST_INVERT_PASS_EN
      S_READ: begin
        cs = 1'b1;
        if (last_idx) begin
          idx_next   = '0;
          state_next = S_INV_WRITE;
        end else begin
          idx_next = idx_reg + IDX_ONE;
        end
      end
      S_INV_WRITE: begin
        cs      = 1'b1;
        wr      = 1'b1;
        pat_inv = 1'b1;
        if (last_idx) begin
          idx_next   = '0;
          state_next = S_INV_READ;
        end else begin
          idx_next = idx_reg + IDX_ONE;
        end
      end
      S_INV_READ: begin
        pat_inv = 1'b1;
        if (rd_end) begin
          state_next = S_DRAIN;
        end else begin
          cs       = 1'b1;
          idx_next = idx_reg + IDX_ONE;
        end
      end
`else
      S_READ: begin
        if (rd_end) begin
          state_next = S_DRAIN;
        end else begin
          cs       = 1'b1;
          idx_next = idx_reg + IDX_ONE;
        end
      end
`endif
      S_DRAIN: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      base_reg  <= '0;
      len_reg   <= '0;
      seed_reg  <= '0;
      clken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      clken_reg <= 1'b1;
      if ((state_reg == S_IDLE) && start) begin
        base_reg <= base_addr;
        len_reg  <= length;
        seed_reg <= seed;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_reg   <= 1'b0;
      exp1_reg      <= '0;
      addr1_reg     <= '0;
      cmp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      exp2_reg      <= '0;
      addr2_reg     <= '0;
    end else begin
      rd_pend_reg   <= cs & ~wr;
      exp1_reg      <= exp_cur;
      addr1_reg     <= address;
      cmp_valid_reg <= rd_pend_reg;
      rdata_reg     <= readdata;
      exp2_reg      <= exp1_reg;
      addr2_reg     <= addr1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_reg     <= 1'b0;
      err_count_reg <= '0;
      err_addr_reg  <= '0;
      err_data_reg  <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      error_reg     <= 1'b0;
      err_count_reg <= '0;
      err_addr_reg  <= '0;
      err_data_reg  <= '0;
    end else if ((state_reg == S_CHECK) && (len_reg != '0) && range_bad) begin
      error_reg <= 1'b1;
    end else if (mismatch) begin
      if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
      if (!error_reg) begin
        error_reg    <= 1'b1;
        err_addr_reg <= addr2_reg;
        err_data_reg <= rdata_reg;
      end
    end
  end

  assign chipselect = cs;
  assign write      = wr;
  assign address    = cs ? (base_reg + idx_reg[ADDR_W-1:0]) : '0;
  assign writedata  = wr ? exp_cur : '0;
  assign byteenable = {BE_W{cs}};
  assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done       = (state_reg == S_DONE);
  assign clken      = clken_reg;
  assign error      = error_reg;
  assign err_count  = err_count_reg;
  assign err_addr   = err_addr_reg;
  assign err_data   = err_data_reg;

endmodule

// File: tb/tb_nios_system_mem_test_master.sv
// Directed bench for nios_system_mem_test_master against a 1-cycle-latency memory model with fault injection.
module tb_nios_system_mem_test_master;

`ifdef NIOS_SYSTEM_MEM_TEST_INVERT_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] length;
  logic [31:0] seed;
  logic        busy, done, error;
  logic [15:0] err_count;
  logic [12:0] err_addr;
  logic [31:0] err_data;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, write;
  logic [31:0] writedata;
  logic        clken;
  logic [31:0] readdata;

  nios_system_mem_test_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done), .error(error),
    .err_count(err_count), .err_addr(err_addr), .err_data(err_data),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, optional faults on the read path.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_q = '0;
  int          fault_mode = 0;
  always @(posedge clk) begin
    if (chipselect) begin
      if (write)                                    mem[address] <= writedata;
      else if (fault_mode == 2)                     rd_q <= 32'h0;
      else if (fault_mode == 1 && address == 13'h105) rd_q <= mem[address] ^ 32'h8;
      else                                          rd_q <= mem[address];
    end
  end
  assign readdata = rd_q;

  int cyc_cnt = 0;
  int cyc_base = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [12:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [12:0] rd_addr_q[$];
  int cs_count, first_wr_cyc, first_rd_cyc;
  always @(negedge clk) begin
    if (chipselect === 1'b1) begin
      cs_count++;
      if (write) begin
        wr_addr_q.push_back(address);
        wr_data_q.push_back(writedata);
        if (first_wr_cyc < 0) first_wr_cyc = cyc_cnt - cyc_base;
      end else begin
        rd_addr_q.push_back(address);
        if (first_rd_cyc < 0) first_rd_cyc = cyc_cnt - cyc_base;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    cs_count     = 0;
    first_wr_cyc = -1;
    first_rd_cyc = -1;
  endtask

  // Issues start in cycle 0 and returns the cycle in which done is seen (-1 on timeout).
  task automatic run_test(input logic [12:0] b, input logic [13:0] l, input logic [31:0] s,
                          input int glitch_cyc, output int done_cyc);
    clear_log();
    @(negedge clk);
    base_addr = b;
    length    = l;
    seed      = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    cyc_base  = cyc_cnt - 1;
    start     = 1'b0;
    base_addr = ~b;
    length    = ~l;
    seed      = ~s;
    done_cyc  = -1;
    for (int c = 1; c <= 400; c++) begin
      if (c == glitch_cyc) begin
        start     = 1'b1;
        base_addr = 13'h40;
        length    = 14'd3;
        seed      = 32'h0;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  int dc;
  logic [31:0] inv_exp [8];

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    clear_log();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_err_count", {48'd0, err_count}, 64'd0);
    check("rst_chipselect", {63'd0, chipselect}, 64'd0);
    check("rst_address", {51'd0, address}, 64'd0);
    check("rst_writedata", {32'd0, writedata}, 64'd0);
    check("rst_byteenable", {60'd0, byteenable}, 64'd0);
    check("rst_clken", {63'd0, clken}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("clken_after_reset", {63'd0, clken}, 64'd1);

    // Clean pass
    fault_mode = 0;
    run_test(13'h100, 14'd16, 32'hA5A50000, 0, dc);
    check("clean_done_cycle", 64'(dc), 64'(2 * PASSES * 16 + 4));
    check("clean_error", {63'd0, error}, 64'd0);
    check("clean_err_count", {48'd0, err_count}, 64'd0);
    check("clean_n_writes", 64'(wr_data_q.size()), 64'(PASSES * 16));
    check("clean_n_reads", 64'(rd_addr_q.size()), 64'(PASSES * 16));
    check("clean_first_wr_cycle", 64'(first_wr_cyc), 64'd2);
    check("clean_first_rd_cycle", 64'(first_rd_cyc), 64'd18);
    check("clean_wdata0", {32'd0, wr_data_q[0]}, 64'hA5A50000);
    check("clean_wdata15", {32'd0, wr_data_q[15]}, 64'hA5A5000F);
    check("clean_waddr15", {51'd0, wr_addr_q[15]}, 64'h10F);
    check("clean_raddr0", {51'd0, rd_addr_q[0]}, 64'h100);

    // Single fault: bit 3 flipped at 0x105
    fault_mode = 1;
    run_test(13'h100, 14'd16, 32'hA5A50000, 0, dc);
    check("fault1_error", {63'd0, error}, 64'd1);
    check("fault1_err_count", {48'd0, err_count}, 64'(PASSES));
    check("fault1_err_addr", {51'd0, err_addr}, 64'h105);
    check("fault1_err_data", {32'd0, err_data}, 64'hA5A5000D);

    // Every read returns zero
    fault_mode = 2;
    run_test(13'h200, 14'd20, 32'h12345678, 0, dc);
    check("multi_done_cycle", 64'(dc), 64'(2 * PASSES * 20 + 4));
    check("multi_err_count", {48'd0, err_count}, 64'(PASSES * 20));
    check("multi_err_addr", {51'd0, err_addr}, 64'h200);
    check("multi_err_data", {32'd0, err_data}, 64'h0);
    fault_mode = 0;

    // length = 0
    run_test(13'h10, 14'd0, 32'h1, 0, dc);
    check("len0_done_cycle", 64'(dc), 64'd2);
    check("len0_error", {63'd0, error}, 64'd0);
    check("len0_no_access", 64'(cs_count), 64'd0);

    // Range overruns DEPTH
    run_test(13'd7990, 14'd11, 32'h1, 0, dc);
    check("oob_done_cycle", 64'(dc), 64'd2);
    check("oob_error", {63'd0, error}, 64'd1);
    check("oob_no_access", 64'(cs_count), 64'd0);

    // Range ends exactly at the last word
    run_test(13'd7990, 14'd10, 32'hDEAD0000, 0, dc);
    check("edge_done_cycle", 64'(dc), 64'(2 * PASSES * 10 + 4));
    check("edge_error", {63'd0, error}, 64'd0);
    check("edge_last_waddr", {51'd0, wr_addr_q[9]}, 64'd7999);
    check("edge_n_access", 64'(cs_count), 64'(2 * PASSES * 10));

    // start while busy is ignored
    run_test(13'h10, 14'd8, 32'h100, 4, dc);
    check("busy_start_done_cycle", 64'(dc), 64'(2 * PASSES * 8 + 4));
    check("busy_start_n_writes", 64'(wr_data_q.size()), 64'(PASSES * 8));
    check("busy_start_waddr0", {51'd0, wr_addr_q[0]}, 64'h10);
    check("busy_start_wdata7", {32'd0, wr_data_q[7]}, 64'h107);
    check("busy_start_error", {63'd0, error}, 64'd0);

    // Asynchronous reset during the 5th write
    clear_log();
    @(negedge clk);
    base_addr = 13'h0; length = 14'd16; seed = 32'h55; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("midrst_cs_before", {63'd0, chipselect}, 64'd1);
    check("midrst_addr_before", {51'd0, address}, 64'd4);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_chipselect", {63'd0, chipselect}, 64'd0);
    check("midrst_write", {63'd0, write}, 64'd0);
    check("midrst_address", {51'd0, address}, 64'd0);
    check("midrst_writedata", {32'd0, writedata}, 64'd0);
    check("midrst_byteenable", {60'd0, byteenable}, 64'd0);
    check("midrst_clken", {63'd0, clken}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_clken", {63'd0, clken}, 64'd1);
    check("postrst_busy", {63'd0, busy}, 64'd0);
    run_test(13'h20, 14'd2, 32'h7, 0, dc);
    check("postrst_done_cycle", 64'(dc), 64'(2 * PASSES * 2 + 4));
    check("postrst_error", {63'd0, error}, 64'd0);

`ifdef NIOS_SYSTEM_MEM_TEST_INVERT_PASS_EN
    // Inverted second pass
    inv_exp = '{32'h0, 32'h1, 32'h2, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
    run_test(13'h0, 14'd4, 32'h0, 0, dc);
    check("inv_done_cycle", 64'(dc), 64'd20);
    check("inv_n_writes", 64'(wr_data_q.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < wr_data_q.size()) check($sformatf("inv_wdata%0d", k), {32'd0, wr_data_q[k]}, {32'd0, inv_exp[k]});
    end
    check("inv_error", {63'd0, error}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
